hazard_controller: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage core (F/D/E/M/W).
- Drives the stall, flush and hold controls of the fetch register, the F/D register and the D/E register.
- Generates the operand-forwarding selects for the execute stage.
- Sequences multi-cycle execute operations (MUL/MLA) by holding the E stage for a programmable number of cycles. Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/hazard_controller.sv | 139 +++++++++++++
 tb/tb_hazard_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries register addresses, write enables and the stall/flush/forward controls.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       RA1E;
    logic [3:0]       RA2E;
    logic [3:0]       WA3E;
    logic [3:0]       WA3M;
    logic [3:0]       WA3W;
    logic             RegWE;
    logic             MemtoRegE;
    logic             RegWM;
    logic             RegWW;
    logic             BranchTakenE;
    logic             MultiCycleE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             StallE;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MCBusy;
    logic             MCDone;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWE, MemtoRegE, RegWM, RegWW, BranchTakenE, MultiCycleE,
        input  StallF, StallD, FlushD, StallE, FlushE,
        input  ForwardAE, ForwardBE, MCBusy, MCDone, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWE, MemtoRegE, RegWM, RegWW, BranchTakenE, MultiCycleE,
        output StallF, StallD, FlushD, StallE, FlushE,
        output ForwardAE, ForwardBE, MCBusy, MCDone, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for the 5-stage core: forwarding selects, load-use
// stalls, branch flushes, multi-cycle E-stage sequencing and a stall-cycle counter.
module hazard_controller #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input logic                 CLK,
    input logic                 RESET,
    hazard_controller_if.slave  hz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // cnt holds the number of BUSY cycles still to run after the first stalled cycle.
    localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 2);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic ld_stall;
    logic stall_f, stall_d, flush_d, stall_e, flush_e, mc_busy, mc_done;

    logic [3:0] ra_e [2];
    logic [1:0] fwd  [2];

    assign ra_e[0] = hz.RA1E;
    assign ra_e[1] = hz.RA2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (!RESET && ra_e[gi] != 4'hF) begin
                    if (hz.RegWM && hz.WA3M == ra_e[gi]) begin
                        fwd[gi] = 2'b10;
                    end else if (hz.RegWW && hz.WA3W == ra_e[gi]) begin
                        fwd[gi] = 2'b01;
                    end
                end
            end
        end
    endgenerate

    assign ld_stall = hz.MemtoRegE && hz.RegWE &&
                      (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        mc_busy = 1'b0;
        mc_done = 1'b0;

        if (RESET) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A branch alongside a multi-cycle op is treated as the branch.
                    if (hz.MultiCycleE && !hz.BranchTakenE) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        mc_busy = 1'b1;
                        cnt_d   = MC_LOAD;
                        state_d = (MC_LOAD == 4'd0) ? DONE : BUSY;
                    end else if (hz.BranchTakenE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (ld_stall) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                BUSY: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    mc_busy = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    mc_done = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_f && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.FlushD     = flush_d;
    assign hz.StallE     = stall_e;
    assign hz.FlushE     = flush_e;
    assign hz.ForwardAE  = fwd[0];
    assign hz.ForwardBE  = fwd[1];
    assign hz.MCBusy     = mc_busy;
    assign hz.MCDone     = mc_done;
    assign hz.StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: a 16-bit-counter instance for the
// functional scenarios and a 4-bit-counter instance for counter saturation.
module tb_hazard_controller;

    logic CLK;
    logic RESET;

    int n_checks;
    int n_pass;

    hazard_controller_if #(.CNT_W(16)) hz_main ();
    hazard_controller_if #(.CNT_W(4))  hz_sat ();

    hazard_controller #(.MC_LATENCY(4), .CNT_W(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .hz    (hz_main.slave)
    );

    hazard_controller #(.MC_LATENCY(4), .CNT_W(4)) dut_sat (
        .CLK   (CLK),
        .RESET (RESET),
        .hz    (hz_sat.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %s ok: %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_main();
        hz_main.RA1D = 4'd0; hz_main.RA2D = 4'd0; hz_main.RA1E = 4'd0; hz_main.RA2E = 4'd0;
        hz_main.WA3E = 4'd0; hz_main.WA3M = 4'd0; hz_main.WA3W = 4'd0;
        hz_main.RegWE = 1'b0; hz_main.MemtoRegE = 1'b0; hz_main.RegWM = 1'b0;
        hz_main.RegWW = 1'b0; hz_main.BranchTakenE = 1'b0; hz_main.MultiCycleE = 1'b0;
    endtask

    task automatic set_load_use();
        hz_main.MemtoRegE = 1'b1; hz_main.RegWE = 1'b1;
        hz_main.WA3E = 4'd2; hz_main.RA2D = 4'd2; hz_main.RA1D = 4'd7;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RESET    = 1'b1;
        clear_main();
        hz_sat.RA1D = 4'd0; hz_sat.RA2D = 4'd0; hz_sat.RA1E = 4'd0; hz_sat.RA2E = 4'd0;
        hz_sat.WA3E = 4'd0; hz_sat.WA3M = 4'd0; hz_sat.WA3W = 4'd0;
        hz_sat.RegWE = 1'b0; hz_sat.MemtoRegE = 1'b0; hz_sat.RegWM = 1'b0;
        hz_sat.RegWW = 1'b0; hz_sat.BranchTakenE = 1'b0; hz_sat.MultiCycleE = 1'b0;

        // Reset state, with a forwarding match present that must be suppressed
        hz_main.RegWM = 1'b1; hz_main.WA3M = 4'd3; hz_main.RA1E = 4'd3;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check_val("rst_flushd", 32'(hz_main.FlushD), 32'd1);
        check_val("rst_flushe", 32'(hz_main.FlushE), 32'd1);
        check_val("rst_stallf", 32'(hz_main.StallF), 32'd0);
        check_val("rst_stalle", 32'(hz_main.StallE), 32'd0);
        check_val("rst_mcbusy", 32'(hz_main.MCBusy), 32'd0);
        check_val("rst_fwda",   32'(hz_main.ForwardAE), 32'd0);
        check_val("rst_count",  32'(hz_main.StallCount), 32'd0);

        // Forwarding: M has priority over W
        next_cycle();
        RESET = 1'b0;
        clear_main();
        hz_main.RegWM = 1'b1; hz_main.WA3M = 4'd3;
        hz_main.RegWW = 1'b1; hz_main.WA3W = 4'd3;
        hz_main.RA1E = 4'd3;  hz_main.RA2E = 4'd5;
        @(negedge CLK);
        check_val("fwd_a_m",   32'(hz_main.ForwardAE), 32'd2);
        check_val("fwd_b_none", 32'(hz_main.ForwardBE), 32'd0);
        check_val("idle_flushd", 32'(hz_main.FlushD), 32'd0);
        next_cycle();
        hz_main.RegWM = 1'b0;
        @(negedge CLK);
        check_val("fwd_a_w", 32'(hz_main.ForwardAE), 32'd1);
        next_cycle();
        hz_main.RegWM = 1'b1; hz_main.WA3M = 4'd15; hz_main.WA3W = 4'd15; hz_main.RA1E = 4'd15;
        hz_main.RA2E = 4'd9; hz_main.RegWW = 1'b1;
        @(negedge CLK);
        check_val("fwd_a_r15", 32'(hz_main.ForwardAE), 32'd0);
        next_cycle();
        hz_main.RegWM = 1'b1; hz_main.WA3M = 4'd4; hz_main.WA3W = 4'd9; hz_main.RA2E = 4'd9;
        @(negedge CLK);
        check_val("fwd_b_w", 32'(hz_main.ForwardBE), 32'd1);

        // Load-use stall for exactly one cycle
        next_cycle();
        clear_main();
        set_load_use();
        @(negedge CLK);
        check_val("ld_stallf", 32'(hz_main.StallF), 32'd1);
        check_val("ld_stalld", 32'(hz_main.StallD), 32'd1);
        check_val("ld_flushe", 32'(hz_main.FlushE), 32'd1);
        check_val("ld_stalle", 32'(hz_main.StallE), 32'd0);
        check_val("ld_count0", 32'(hz_main.StallCount), 32'd0);
        next_cycle();
        clear_main();
        @(negedge CLK);
        check_val("ld_release", 32'(hz_main.StallF), 32'd0);
        check_val("ld_count1", 32'(hz_main.StallCount), 32'd1);

        // Branch overrides load-use
        next_cycle();
        set_load_use();
        hz_main.BranchTakenE = 1'b1;
        @(negedge CLK);
        check_val("br_flushd", 32'(hz_main.FlushD), 32'd1);
        check_val("br_flushe", 32'(hz_main.FlushE), 32'd1);
        check_val("br_stallf", 32'(hz_main.StallF), 32'd0);
        check_val("br_stalld", 32'(hz_main.StallD), 32'd0);

        // Multi-cycle op, MC_LATENCY=4: stalls on cycles 0-2, MCDone on cycle 3
        next_cycle();
        clear_main();
        hz_main.MultiCycleE = 1'b1;
        @(negedge CLK);
        check_val("mc0_stalle", 32'(hz_main.StallE), 32'd1);
        check_val("mc0_busy",   32'(hz_main.MCBusy), 32'd1);
        check_val("mc0_flushe", 32'(hz_main.FlushE), 32'd0);
        next_cycle();
        hz_main.BranchTakenE = 1'b1;
        set_load_use();
        @(negedge CLK);
        check_val("mc1_stalle", 32'(hz_main.StallE), 32'd1);
        check_val("mc1_flushd", 32'(hz_main.FlushD), 32'd0);
        check_val("mc1_flushe", 32'(hz_main.FlushE), 32'd0);
        next_cycle();
        hz_main.BranchTakenE = 1'b0;
        hz_main.MemtoRegE = 1'b0;
        @(negedge CLK);
        check_val("mc2_stalle", 32'(hz_main.StallE), 32'd1);
        check_val("mc2_done",   32'(hz_main.MCDone), 32'd0);
        next_cycle();
        @(negedge CLK);
        check_val("mc3_done",   32'(hz_main.MCDone), 32'd1);
        check_val("mc3_stalle", 32'(hz_main.StallE), 32'd0);
        check_val("mc3_stallf", 32'(hz_main.StallF), 32'd0);
        check_val("mc3_busy",   32'(hz_main.MCBusy), 32'd0);
        next_cycle();
        clear_main();
        @(negedge CLK);
        check_val("mc4_done",  32'(hz_main.MCDone), 32'd0);
        check_val("mc4_count", 32'(hz_main.StallCount), 32'd4);

        // Reset in the middle of a multi-cycle op
        next_cycle();
        hz_main.MultiCycleE = 1'b1;
        @(negedge CLK);
        check_val("rmc0_busy", 32'(hz_main.MCBusy), 32'd1);
        next_cycle();
        RESET = 1'b1;
        @(negedge CLK);
        check_val("rmc1_busy", 32'(hz_main.MCBusy), 32'd0);
        next_cycle();
        @(negedge CLK);
        check_val("rmc2_busy",   32'(hz_main.MCBusy), 32'd0);
        check_val("rmc2_count",  32'(hz_main.StallCount), 32'd0);
        check_val("rmc2_flushd", 32'(hz_main.FlushD), 32'd1);
        check_val("rmc2_flushe", 32'(hz_main.FlushE), 32'd1);
        check_val("rmc2_done",   32'(hz_main.MCDone), 32'd0);
        next_cycle();
        RESET = 1'b0;
        clear_main();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_val($sformatf("rmc_nodone%0d", i), 32'(hz_main.MCDone), 32'd0);
            next_cycle();
        end

        // Saturation on the 4-bit counter: load-use held continuously
        hz_sat.MemtoRegE = 1'b1; hz_sat.RegWE = 1'b1; hz_sat.WA3E = 4'd6; hz_sat.RA1D = 4'd6;
        for (int i = 0; i <= 20; i++) begin
            @(negedge CLK);
            check_val($sformatf("sat_count%0d", i), 32'(hz_sat.StallCount),
                      (i < 15) ? 32'(i) : 32'd15);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
